// File: rtl/pool_seq_ctrl_pkg.sv
// Shared definitions for the pooling sequencer: FSM state encoding and the
// pooled-dimension helper reused by the neighbouring layer controllers.
package pool_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_POOL = 3'd3,
        ST_WR   = 3'd4,
        ST_FIN  = 3'd5
    } state_e;

    localparam int NUM_TAPS = 4;

    // 2x2 stride-2 pooling output size; an odd trailing row/column is dropped.
    function automatic int pool_out_dim(input int n);
        return n / 2;
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/tap counters for the 2x2 pooling pass; produces the input-buffer read
// address, the output-buffer write address and a last-window flag.
module pool_addr_gen
    import pool_seq_ctrl_pkg::*;
#(
    parameter int IMG_W = 24,
    parameter int IMG_H = 24,
    parameter int RD_AW = 10,
    parameter int WR_AW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             k_inc,
    input  logic             win_adv,
    output logic [1:0]       k,
    output logic             k_last,
    output logic             last_window,
    output logic [RD_AW-1:0] rd_addr,
    output logic [WR_AW-1:0] wr_addr
);

    localparam int OUT_W = pool_out_dim(IMG_W);
    localparam int OUT_H = pool_out_dim(IMG_H);

    localparam logic [RD_AW-1:0] ROW_PAIR  = RD_AW'(2 * IMG_W);
    localparam logic [WR_AW-1:0] OUT_ROW   = WR_AW'(OUT_W);
    localparam logic [WR_AW-1:0] WC_MAX    = WR_AW'(OUT_W - 1);
    localparam logic [WR_AW-1:0] WR_MAX    = WR_AW'(OUT_H - 1);

    logic [WR_AW-1:0] wr_q, wr_d;
    logic [WR_AW-1:0] wc_q, wc_d;
    logic [1:0]       k_q, k_d;
    logic             wc_last;
    logic             wr_last;
    logic [RD_AW-1:0] rd_base;
    logic [RD_AW-1:0] tap_off [NUM_TAPS];

    // Tap order inside a window: top-left, top-right, bottom-left, bottom-right.
    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
        assign tap_off[gi] = RD_AW'((gi / 2) * IMG_W + (gi % 2));
    end

    assign wc_last     = (wc_q == WC_MAX);
    assign wr_last     = (wr_q == WR_MAX);
    assign last_window = wc_last && wr_last;
    assign k           = k_q;
    assign k_last      = (k_q == 2'd3);

    always_comb begin
        rd_base = ROW_PAIR * RD_AW'(wr_q) + (RD_AW'(wc_q) << 1);
        rd_addr = rd_base + tap_off[k_q];
        wr_addr = OUT_ROW * wr_q + wc_q;
    end

    always_comb begin
        wr_d = wr_q;
        wc_d = wc_q;
        k_d  = k_q;
        if (clr) begin
            wr_d = '0;
            wc_d = '0;
            k_d  = '0;
        end else begin
            if (k_inc) begin
                k_d = k_q + 2'd1;
            end
            if (win_adv) begin
                if (!wc_last) begin
                    wc_d = wc_q + WR_AW'(1);
                end else begin
                    wc_d = '0;
                    if (!wr_last) begin
                        wr_d = wr_q + WR_AW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            wc_q <= '0;
            k_q  <= '0;
        end else begin
            wr_q <= wr_d;
            wc_q <= wc_d;
            k_q  <= k_d;
        end
    end

endmodule

// File: rtl/pool_seq_ctrl.sv
// 2x2 stride-2 average-pooling sequencer: fetches each window from the input
// buffer, drives the external average unit and writes the pooled result.
module pool_seq_ctrl
    import pool_seq_ctrl_pkg::*;
#(
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int DATA_W = 8,
    parameter int RD_AW  = 10,
    parameter int WR_AW  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [RD_AW-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pool_en,
    output logic [DATA_W-1:0] pool_in1,
    output logic [DATA_W-1:0] pool_in2,
    output logic [DATA_W-1:0] pool_in3,
    output logic [DATA_W-1:0] pool_in4,
    input  logic [DATA_W-1:0] pool_res,
    output logic              wr_en,
    output logic [WR_AW-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    state_e state_q, state_d;

    logic [DATA_W-1:0] pool_in_q [NUM_TAPS];
    logic [DATA_W-1:0] pool_in_d [NUM_TAPS];
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              in_pass;
    logic              abort_hit;
    logic              cnt_clr;
    logic              k_inc;
    logic              win_adv;
    logic [1:0]        k;
    logic              k_last;
    logic              last_window;
    logic [RD_AW-1:0]  gen_rd_addr;
    logic [WR_AW-1:0]  gen_wr_addr;

    pool_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .RD_AW (RD_AW),
        .WR_AW (WR_AW)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (cnt_clr),
        .k_inc       (k_inc),
        .win_adv     (win_adv),
        .k           (k),
        .k_last      (k_last),
        .last_window (last_window),
        .rd_addr     (gen_rd_addr),
        .wr_addr     (gen_wr_addr)
    );

    // FIN is deliberately outside the pass so busy drops on the done cycle.
    assign in_pass   = (state_q == ST_RD) || (state_q == ST_CAP) ||
                       (state_q == ST_POOL) || (state_q == ST_WR);
    assign abort_hit = abort && in_pass;
    assign cnt_clr   = ((state_q == ST_IDLE) && start) || abort_hit;
    assign k_inc     = (state_q == ST_RD);
    assign win_adv   = (state_q == ST_WR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RD;
            ST_RD:   if (k_last) state_d = ST_CAP;
            ST_CAP:  state_d = ST_POOL;
            ST_POOL: state_d = ST_WR;
            ST_WR:   state_d = last_window ? ST_FIN : ST_RD;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Strobes decode straight from the state, so a write in the abort cycle completes.
    always_comb begin
        busy    = in_pass;
        done    = (state_q == ST_FIN);
        rd_en   = (state_q == ST_RD);
        pool_en = (state_q == ST_POOL);
        wr_en   = (state_q == ST_WR);
        rd_addr = rd_en ? gen_rd_addr : '0;
        wr_addr = wr_en ? gen_wr_addr : '0;
        wr_data = wr_en ? pool_res : wr_data_q;
    end

    // Read data lags the strobe by one cycle, so tap k-1 lands while k is issued.
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            pool_in_d[i] = pool_in_q[i];
        end
        if ((state_q == ST_RD) && (k != 2'd0)) begin
            pool_in_d[k - 2'd1] = rd_data;
        end
        if (state_q == ST_CAP) begin
            pool_in_d[NUM_TAPS-1] = rd_data;
        end
        wr_data_d = (state_q == ST_WR) ? pool_res : wr_data_q;
    end

    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_pix
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pool_in_q[gi] <= '0;
            end else begin
                pool_in_q[gi] <= pool_in_d[gi];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign pool_in1 = pool_in_q[0];
    assign pool_in2 = pool_in_q[1];
    assign pool_in3 = pool_in_q[2];
    assign pool_in4 = pool_in_q[3];

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Directed bench for pool_seq_ctrl: a 4x4 and a 5x5 instance with buffer and
// average-unit models, checked against hand-computed pooled values.
module tb_pool_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic sel5  = 1'b0;

    logic start4, start5, abort4, abort5;
    assign start4 = start & ~sel5;
    assign start5 = start & sel5;
    assign abort4 = abort & ~sel5;
    assign abort5 = abort & sel5;

    // ---------------- 4x4 instance ----------------
    logic       busy4, done4, rd_en4, pool_en4, wr_en4;
    logic [9:0] rd_addr4;
    logic [7:0] rd_data4, pool_res4, pa4, pb4, pc4, pd4, wr_data4;
    logic [7:0] wr_addr4;
    logic [7:0] mem4 [0:15];

    pool_seq_ctrl #(.IMG_W(4), .IMG_H(4), .DATA_W(8), .RD_AW(10), .WR_AW(8)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .busy(busy4), .done(done4), .rd_en(rd_en4), .rd_addr(rd_addr4),
        .rd_data(rd_data4), .pool_en(pool_en4), .pool_in1(pa4), .pool_in2(pb4),
        .pool_in3(pc4), .pool_in4(pd4), .pool_res(pool_res4), .wr_en(wr_en4),
        .wr_addr(wr_addr4), .wr_data(wr_data4)
    );

    // ---------------- 5x5 instance ----------------
    logic       busy5, done5, rd_en5, pool_en5, wr_en5;
    logic [9:0] rd_addr5;
    logic [7:0] rd_data5, pool_res5, pa5, pb5, pc5, pd5, wr_data5;
    logic [7:0] wr_addr5;
    logic [7:0] mem5 [0:24];

    pool_seq_ctrl #(.IMG_W(5), .IMG_H(5), .DATA_W(8), .RD_AW(10), .WR_AW(8)) u5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .abort(abort5),
        .busy(busy5), .done(done5), .rd_en(rd_en5), .rd_addr(rd_addr5),
        .rd_data(rd_data5), .pool_en(pool_en5), .pool_in1(pa5), .pool_in2(pb5),
        .pool_in3(pc5), .pool_in4(pd5), .pool_res(pool_res5), .wr_en(wr_en5),
        .wr_addr(wr_addr5), .wr_data(wr_data5)
    );

    // Buffer and average-unit models (floor of the 4-pixel mean).
    logic [9:0] sum4, sum5;
    assign sum4 = 10'(pa4) + 10'(pb4) + 10'(pc4) + 10'(pd4);
    assign sum5 = 10'(pa5) + 10'(pb5) + 10'(pc5) + 10'(pd5);

    always @(posedge clk) begin
        if (rd_en4) rd_data4 <= mem4[rd_addr4[3:0]];
        if (rd_en5) rd_data5 <= mem5[rd_addr5[4:0]];
        if (pool_en4) pool_res4 <= sum4[9:2];
        if (pool_en5) pool_res5 <= sum5[9:2];
    end

    // Observed view of whichever instance is selected.
    logic       o_busy, o_done, o_rd_en, o_pool_en, o_wr_en;
    logic [9:0] o_rd_addr;
    logic [7:0] o_wr_addr, o_wr_data, o_pa, o_pd;
    assign o_busy    = sel5 ? busy5    : busy4;
    assign o_done    = sel5 ? done5    : done4;
    assign o_rd_en   = sel5 ? rd_en5   : rd_en4;
    assign o_pool_en = sel5 ? pool_en5 : pool_en4;
    assign o_wr_en   = sel5 ? wr_en5   : wr_en4;
    assign o_rd_addr = sel5 ? rd_addr5 : rd_addr4;
    assign o_wr_addr = sel5 ? wr_addr5 : wr_addr4;
    assign o_wr_data = sel5 ? wr_data5 : wr_data4;
    assign o_pa      = sel5 ? pa5      : pa4;
    assign o_pd      = sel5 ? pd5      : pd4;

    int nvec = 0;
    int nmis = 0;

    int rel;
    int nw, nr, ndone, done_at, nbusy, busy_first, busy_last, overlap, max_rd, bad_rd;
    logic [31:0] wa [0:15];
    logic [31:0] wd [0:15];
    logic [31:0] rlog [0:63];
    bit          busy_hist [0:63];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        nw = 0; nr = 0; ndone = 0; done_at = -1; nbusy = 0;
        busy_first = -1; busy_last = -1; overlap = 0; max_rd = 0; bad_rd = 0;
        for (int i = 0; i < 64; i++) busy_hist[i] = 1'b0;
    endtask

    // Advance to the next negedge and record what the selected DUT did this cycle.
    task automatic step();
        @(negedge clk);
        rel++;
        if (o_wr_en) begin
            if (nw < 16) begin
                wa[nw] = 32'(o_wr_addr);
                wd[nw] = 32'(o_wr_data);
            end
            nw++;
        end
        if (o_rd_en) begin
            if (nr < 64) rlog[nr] = 32'(o_rd_addr);
            nr++;
            if (int'(o_rd_addr) > max_rd) max_rd = int'(o_rd_addr);
            if (sel5 && ((o_rd_addr % 10'd5) == 10'd4 || o_rd_addr >= 10'd20)) bad_rd++;
        end
        if (o_done) begin
            ndone++;
            done_at = rel;
        end
        if (o_busy) begin
            nbusy++;
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
            if (rel < 64) busy_hist[rel] = 1'b1;
        end
        if ((int'(o_rd_en) + int'(o_pool_en) + int'(o_wr_en)) > 1) overlap++;
    endtask

    // Start is driven in cycle 0; abort/reset are injected in the named cycle.
    task automatic run_pass(input int budget, input bit hold, input int abort_at, input int rst_at);
        clear_log();
        rel   = 0;
        start = 1'b1;
        while (rel < budget) begin
            step();
            start = hold;
            abort = (rel == abort_at);
            if (rel == rst_at) begin
                check("pre_rst_rd_en", 32'(o_rd_en), 32'd1);
                rst_n = 1'b0;
                #1;
                check("rst_busy", 32'(o_busy), 32'd0);
                check("rst_rd_en", 32'(o_rd_en), 32'd0);
                check("rst_rd_addr", 32'(o_rd_addr), 32'd0);
                check("rst_pool_in1", 32'(o_pa), 32'd0);
                check("rst_wr_data", 32'(o_wr_data), 32'd0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic check_full_pass(input logic [31:0] e0, input logic [31:0] e1,
                                   input logic [31:0] e2, input logic [31:0] e3,
                                   input logic [31:0] last_rd);
        check("n_writes", 32'(nw), 32'd4);
        check("wr_addr0", wa[0], 32'd0);
        check("wr_addr1", wa[1], 32'd1);
        check("wr_addr2", wa[2], 32'd2);
        check("wr_addr3", wa[3], 32'd3);
        check("wr_data0", wd[0], e0);
        check("wr_data1", wd[1], e1);
        check("wr_data2", wd[2], e2);
        check("wr_data3", wd[3], e3);
        check("n_done", 32'(ndone), 32'd1);
        check("done_cycle", 32'(done_at), 32'd29);
        check("busy_first", 32'(busy_first), 32'd1);
        check("busy_last", 32'(busy_last), 32'd28);
        check("busy_cycles", 32'(nbusy), 32'd28);
        check("n_reads", 32'(nr), 32'd16);
        check("strobe_overlap", 32'(overlap), 32'd0);
        check("max_rd_addr", 32'(max_rd), last_rd);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem4[i] = 8'(i);
        for (int i = 0; i < 25; i++) mem5[i] = 8'(i);
        clear_log();
        rel = 0;

        // Reset state
        step();
        step();
        check("reset_busy", 32'(busy4), 32'd0);
        check("reset_done", 32'(done4), 32'd0);
        check("reset_rd_en", 32'(rd_en4), 32'd0);
        check("reset_wr_en", 32'(wr_en4), 32'd0);
        check("reset_pool_en", 32'(pool_en4), 32'd0);
        check("reset_wr_data", 32'(wr_data4), 32'd0);
        check("reset_pool_in4", 32'(pd4), 32'd0);
        rst_n = 1'b1;
        step();

        // 4x4 ramp: windows average to 2, 4, 10, 12
        run_pass(34, 1'b0, -1, -1);
        check_full_pass(32'd2, 32'd4, 32'd10, 32'd12, 32'd15);
        check("first_rd_addrs", {rlog[0][7:0], rlog[1][7:0], rlog[2][7:0], rlog[3][7:0]},
              {8'd0, 8'd1, 8'd4, 8'd5});
        check("held_pool_in1", 32'(pa4), 32'd10);
        check("held_pool_in4", 32'(pd4), 32'd15);
        check("held_wr_data", 32'(wr_data4), 32'd12);

        // All-255 map
        for (int i = 0; i < 16; i++) mem4[i] = 8'd255;
        run_pass(34, 1'b0, -1, -1);
        check_full_pass(32'd255, 32'd255, 32'd255, 32'd255, 32'd15);

        // 5x5 ramp: last column and row dropped
        sel5 = 1'b1;
        step();
        run_pass(34, 1'b0, -1, -1);
        check_full_pass(32'd3, 32'd5, 32'd13, 32'd15, 32'd18);
        check("win01_rd_addrs", {rlog[4][7:0], rlog[5][7:0], rlog[6][7:0], rlog[7][7:0]},
              {8'd2, 8'd3, 8'd7, 8'd8});
        check("dropped_reads", 32'(bad_rd), 32'd0);
        sel5 = 1'b0;
        step();

        // Abort on the second window's POOL cycle (cycle 13)
        for (int i = 0; i < 16; i++) mem4[i] = 8'(i);
        run_pass(34, 1'b0, 13, -1);
        check("abort_n_writes", 32'(nw), 32'd1);
        check("abort_wr_addr0", wa[0], 32'd0);
        check("abort_busy_last", 32'(busy_last), 32'd13);
        check("abort_busy_after", 32'(busy_hist[14]), 32'd0);
        check("abort_n_done", 32'(ndone), 32'd0);
        check("abort_overlap", 32'(overlap), 32'd0);
        run_pass(34, 1'b0, -1, -1);
        check_full_pass(32'd2, 32'd4, 32'd10, 32'd12, 32'd15);

        // Asynchronous reset during RD of the third window (cycle 16)
        run_pass(25, 1'b0, -1, 16);
        check("rst_n_done", 32'(ndone), 32'd0);
        check("rst_busy_last", 32'(busy_last), 32'd16);
        step();
        run_pass(34, 1'b0, -1, -1);
        check_full_pass(32'd2, 32'd4, 32'd10, 32'd12, 32'd15);

        // start held through FIN: one done, relaunch only from IDLE
        run_pass(32, 1'b1, -1, -1);
        check("hold_n_done", 32'(ndone), 32'd1);
        check("hold_done_cycle", 32'(done_at), 32'd29);
        check("hold_busy_fin", 32'(busy_hist[29]), 32'd0);
        check("hold_busy_idle", 32'(busy_hist[30]), 32'd0);
        check("hold_busy_relaunch", 32'(busy_hist[31]), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        check("final_busy", 32'(busy4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
